imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch-stage instruction interface.
- Serves word-aligned fetch requests through a LATENCY-deep read pipeline.
- Supports flushing of in-flight responses on a taken branch.
- Replaces the hard-coded program image with a runtime load port that writes words sequentially from address 0.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_read_pipe.sv | 66 ++++++
 rtl/imem_responder.sv | 103 ++++++++++
 tb/tb_imem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory responder.
// Word geometry and load FSM state encoding.
package imem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    function automatic logic misaligned(input logic [WORD_W-1:0] addr);
        return |addr[BYTE_OFF_W-1:0];
    endfunction

endpackage

// File: rtl/imem_read_pipe.sv
// LATENCY-stage response shift register with a synchronous flush.
// Stage 0 loads the accepted request; flush only kills older stages.
module imem_read_pipe
    import imem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic [WORD_W-1:0] in_addr,
    input  logic              in_err,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [WORD_W-1:0] out_addr,
    output logic              out_err
);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [WORD_W-1:0]  data_q [LATENCY];
    logic [WORD_W-1:0]  addr_q [LATENCY];

    // The request accepted alongside a flush is the branch target: keep it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q[0]  <= 1'b0;
            err_q[0]  <= 1'b0;
            data_q[0] <= '0;
            addr_q[0] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                err_q[0]  <= in_err;
                data_q[0] <= in_data;
                addr_q[0] <= in_addr;
            end
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld_q[g]  <= 1'b0;
                err_q[g]  <= 1'b0;
                data_q[g] <= '0;
                addr_q[g] <= '0;
            end else begin
                vld_q[g] <= vld_q[g-1] && !flush;
                if (vld_q[g-1]) begin
                    err_q[g]  <= err_q[g-1];
                    data_q[g] <= data_q[g-1];
                    addr_q[g] <= addr_q[g-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
    assign out_addr  = addr_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction memory end of the fetch interface: pipelined reads,
// branch flush, and a sequential runtime program-load port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [WORD_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_data,
    output logic [WORD_W-1:0] resp_addr,
    output logic              resp_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [AW-1:0]     wptr;
    logic              wr_en;
    logic              wr_done;

    logic              accept;
    logic [AW-1:0]     rd_idx;
    logic              rd_oor;
    logic              rd_err;
    logic [WORD_W-1:0] rd_data;

    assign req_ready = (state == ST_IDLE) && !load_start;
    assign accept    = req_valid && req_ready;
    assign load_busy = (state == ST_LOAD);

    assign rd_idx  = req_addr[AW+1:BYTE_OFF_W];
    assign rd_oor  = |req_addr[WORD_W-1:AW+BYTE_OFF_W];
    assign rd_err  = misaligned(req_addr) || rd_oor;
    assign rd_data = rd_err ? '0 : mem[rd_idx];

    assign wr_en   = (state == ST_LOAD) && load_valid;
    assign wr_done = load_last || (wptr == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            wptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state <= ST_LOAD;
                        wptr  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        if (wr_done) begin
                            state <= ST_IDLE;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Contents survive reset so a partial load keeps the words written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wptr] <= load_data;
        end
    end

    imem_read_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (rd_data),
        .in_addr   (req_addr),
        .in_err    (rd_err),
        .out_valid (resp_valid),
        .out_data  (resp_data),
        .out_addr  (resp_addr),
        .out_err   (resp_err)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=1 and LATENCY=3 instances
// share one stimulus stream.
module tb_imem_responder;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_load_busy;
    logic [31:0] a_resp_data, a_resp_addr;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_load_busy;
    logic [31:0] b_resp_data, b_resp_addr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] prog [8];

    always #5 clock = ~clock;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_req_ready),
        .flush(flush),
        .resp_valid(a_resp_valid), .resp_data(a_resp_data),
        .resp_addr(a_resp_addr), .resp_err(a_resp_err),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_busy(a_load_busy)
    );

    imem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_req_ready),
        .flush(flush),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data),
        .resp_addr(b_resp_addr), .resp_err(b_resp_err),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_busy(b_load_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        chk({name, "_valid"}, 32'(a_resp_valid), 32'd1);
        chk({name, "_data"}, a_resp_data, exp_data);
        chk({name, "_addr"}, a_resp_addr, addr);
        chk({name, "_err"}, 32'(a_resp_err), 32'(exp_err));
    endtask

    initial begin
        prog[0] = 32'hac030000; prog[1] = 32'h8c040004;
        prog[2] = 32'h00641820; prog[3] = 32'h20050008;
        prog[4] = 32'h10a00002; prog[5] = 32'h00852020;
        prog[6] = 32'h08000000; prog[7] = 32'h00a02820;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{addr: 32'(i * 4), data: prog[i], err: 1'b0};
        end
        vecs[8]  = '{addr: 32'h0000_0002, data: 32'h0, err: 1'b1};
        vecs[9]  = '{addr: 32'h0000_0020, data: 32'h0, err: 1'b1};
        vecs[10] = '{addr: 32'h0000_001c, data: prog[7], err: 1'b0};
        vecs[11] = '{addr: 32'h8000_0004, data: 32'h0, err: 1'b1};

        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_resp_data", a_resp_data, 32'd0);
        chk("rst_load_busy", 32'(a_load_busy), 32'd0);

        // load_start beats a simultaneous request
        load_start = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        #1;
        chk("start_req_ready", 32'(a_req_ready), 32'd0);
        step();
        load_start = 1'b0;
        req_valid  = 1'b0;
        chk("start_no_resp", 32'(a_resp_valid), 32'd0);
        chk("start_busy", 32'(a_load_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            load_word(prog[i], i == 7);
            chk($sformatf("load_busy_%0d", i), 32'(a_load_busy),
                (i == 7) ? 32'd0 : 32'd1);
        end

        // back-to-back fetches, one response per cycle
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(a_resp_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), a_resp_data, vecs[i].data);
            chk($sformatf("vec%0d_addr", i), a_resp_addr, vecs[i].addr);
            chk($sformatf("vec%0d_err", i), 32'(a_resp_err),
                32'(vecs[i].err));
        end
        req_valid = 1'b0;
        step();
        chk("drain_valid", 32'(a_resp_valid), 32'd0);
        step();
        step();
        step();

        // flush on LATENCY=3: only the branch target survives
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr  = 32'h4;
        step();
        req_addr  = 32'h8;
        flush     = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            chk($sformatf("flush_c%0d_valid", c), 32'(b_resp_valid),
                (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("flush_data", b_resp_data, prog[2]);
                chk("flush_addr", b_resp_addr, 32'h8);
            end
            step();
        end

        // short load terminated by load_last on word 2
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_word(32'h1111_0000, 1'b0);
        load_word(32'h1111_0001, 1'b0);
        load_word(32'h1111_0002, 1'b1);
        chk("short_busy", 32'(a_load_busy), 32'd0);
        rd("short0", 32'h0, 32'h1111_0000, 1'b0);
        rd("short1", 32'h4, 32'h1111_0001, 1'b0);
        rd("short2", 32'h8, 32'h1111_0002, 1'b0);
        rd("short3", 32'hc, prog[3], 1'b0);

        // asynchronous reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_word(32'h2222_0000, 1'b0);
        load_word(32'h2222_0001, 1'b0);
        load_word(32'h2222_0002, 1'b0);
        chk("mid_busy", 32'(a_load_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(a_load_busy), 32'd0);
        chk("arst_valid", 32'(a_resp_valid), 32'd0);
        chk("arst_data", a_resp_data, 32'd0);
        chk("arst_addr", a_resp_addr, 32'd0);
        #2;
        reset = 1'b0;
        step();
        chk("arst_req_ready", 32'(a_req_ready), 32'd1);
        rd("mid0", 32'h0, 32'h2222_0000, 1'b0);
        rd("mid1", 32'h4, 32'h2222_0001, 1'b0);
        rd("mid2", 32'h8, 32'h2222_0002, 1'b0);
        rd("mid3", 32'hc, prog[3], 1'b0);

        // a new load restarts at index 0
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_word(32'h3333_0000, 1'b1);
        rd("restart0", 32'h0, 32'h3333_0000, 1'b0);
        rd("restart1", 32'h4, 32'h2222_0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
